// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared MIDI serial definitions: receiver states, status-bit index, bit timing.
package midi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // A MIDI byte with its top bit set is a status byte; data bytes stay below 0x80.
    localparam int MIDI_STATUS_BIT = 7;

    function automatic int calc_bit_clks(input int sysclk_f, input int baud);
        return sysclk_f / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with exact occupancy count.
module sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic [DATA_W-1:0]               wdata,
    input  logic                            pop,
    output logic [DATA_W-1:0]               rdata,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(FIFO_DEPTH):0]     level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (level == LVL_W'(FIFO_DEPTH));
    assign empty   = (level == '0);
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a simultaneous push.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/midi_rx_fifo.sv
// rtl/midi_rx_fifo.sv - MIDI/UART receiver with framing check and output FIFO.
// MIDI_RX_MAJORITY_EN selects 2-of-3 majority sampling around each bit centre.
module midi_rx_fifo
    import midi_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int MIDI_BAUD  = 31250,
    parameter int SYSCLK_F   = 48000000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst,
    input  logic                            midi_in,
    output logic [DATA_W-1:0]               rx_data,
    output logic                            rx_is_status,
    output logic                            rx_valid,
    input  logic                            rx_ready,
    output logic                            framing_err,
    output logic                            overrun_err,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int BIT_CLKS  = calc_bit_clks(SYSCLK_F, MIDI_BAUD);
    localparam int HALF_CLKS = BIT_CLKS / 2;
    localparam int CNT_W     = $clog2(BIT_CLKS);
    localparam int BITS_W    = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BIT_CLKS - 1);
`ifdef MIDI_RX_MAJORITY_EN
    // Deciding at centre+1 pushes every later sample point back by one cycle as well.
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_CLKS);
`else
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_CLKS - 1);
`endif
    localparam logic [BITS_W-1:0] BITS_LAST = BITS_W'(DATA_W - 1);

    rx_state_t          state;
    rx_state_t          state_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic [BITS_W-1:0]  bits;
    logic [BITS_W-1:0]  bits_n;
    logic [DATA_W-1:0]  shreg;
    logic               shift_en;
    logic               push_n;
    logic               push_q;
    logic               ferr_n;
    logic               sync1;
    logic               sync2;
    logic               sync3;
    logic               line;
    logic               fall;
    logic               fifo_full;
    logic               fifo_empty;

`ifdef MIDI_RX_MAJORITY_EN
    logic               sync4;
    assign line = (sync2 & sync3) | (sync2 & sync4) | (sync3 & sync4);
`else
    assign line = sync2;
`endif
    assign fall = sync3 & ~sync2;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            sync3       <= 1'b1;
`ifdef MIDI_RX_MAJORITY_EN
            sync4       <= 1'b1;
`endif
            state       <= ST_IDLE;
            cnt         <= '0;
            bits        <= '0;
            shreg       <= '0;
            push_q      <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            sync1       <= midi_in;
            sync2       <= sync1;
            sync3       <= sync2;
`ifdef MIDI_RX_MAJORITY_EN
            sync4       <= sync3;
`endif
            state       <= state_n;
            cnt         <= cnt_n;
            bits        <= bits_n;
            if (shift_en) begin
                shreg <= {line, shreg[DATA_W-1:1]};
            end
            push_q      <= push_n;
            framing_err <= ferr_n;
            overrun_err <= push_q & fifo_full & ~rx_ready;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        bits_n   = bits;
        shift_en = 1'b0;
        push_n   = 1'b0;
        ferr_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (fall) begin
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    bits_n  = '0;
                    state_n = line ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n    = '0;
                    shift_en = 1'b1;
                    bits_n   = bits + 1'b1;
                    if (bits == BITS_LAST) begin
                        state_n = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (line) begin
                        push_n  = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Hold off until the line recovers so a long break cannot look like a new start.
                cnt_n = '0;
                if (sync2) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (push_q),
        .wdata (shreg),
        .pop   (rx_ready),
        .rdata (rx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign rx_valid     = ~fifo_empty;
    assign rx_is_status = rx_data[DATA_W-1];

endmodule

// File: tb/tb_midi_rx_fifo.sv
// tb/tb_midi_rx_fifo.sv - self-checking bench for midi_rx_fifo against a queue model of received bytes.
module tb_midi_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int SYSF  = 500000;
    localparam int BAUD  = 31250;
    localparam int BIT   = SYSF / BAUD;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          midi_in = 1'b1;
    logic          rx_ready = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_is_status;
    logic          rx_valid;
    logic          framing_err;
    logic          overrun_err;
    logic [$clog2(DEPTH):0] fifo_level;

    int            n_tests = 0;
    int            n_fail = 0;
    int            ferr_cnt = 0;
    int            ovr_cnt = 0;
    int            ferr_snap;
    int            ovr_snap;
    logic [7:0]    exp_q[$];
    logic [7:0]    burst[5];
    bit            abort_tx = 1'b0;
    bit            rand_ready = 1'b0;

    midi_rx_fifo #(
        .DATA_W     (DW),
        .MIDI_BAUD  (BAUD),
        .SYSCLK_F   (SYSF),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .midi_in      (midi_in),
        .rx_data      (rx_data),
        .rx_is_status (rx_is_status),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .framing_err  (framing_err),
        .overrun_err  (overrun_err),
        .fifo_level   (fifo_level)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Consumer side: every accepted byte must be the oldest byte the model expects.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (framing_err) ferr_cnt++;
            if (overrun_err) ovr_cnt++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    check("model_has_byte_for_pop", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("rx_data", 32'(rx_data), 32'(exp_q[0]));
                    check("rx_is_status", 32'(rx_is_status), 32'(exp_q[0][7]));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    always @(posedge sys_clk) begin
        if (rand_ready) begin
            #1 rx_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        midi_in = 1'b1;
        wait_cycles(n);
    endtask

    // One frame, LSB first; the model learns of the byte before its stop bit goes out.
    task automatic send_byte(input logic [7:0] b, input bit stop, input bit model_push);
        logic v;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      v = 1'b0;
            else if (i == 9) v = stop;
            else             v = b[i-1];
            if (i == 9 && model_push) exp_q.push_back(b);
            midi_in = v;
            for (int c = 0; c < BIT; c++) begin
                @(posedge sys_clk);
                #1;
                if (abort_tx) begin
                    midi_in = 1'b1;
                    return;
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_data"}, 32'(rx_data), 32'd0);
        check({tag, "_status"}, 32'(rx_is_status), 32'd0);
        check({tag, "_ferr"}, 32'(framing_err), 32'd0);
        check({tag, "_ovr"}, 32'(overrun_err), 32'd0);
        check({tag, "_level"}, 32'(fifo_level), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_cycles(5);
        check_reset_outputs("reset");
        sys_rst = 1'b0;
        idle(5);

        // Single status byte, held until the consumer is ready.
        send_byte(8'h90, 1'b1, 1'b1);
        idle(20);
        check("t1_valid", 32'(rx_valid), 32'd1);
        check("t1_data", 32'(rx_data), 32'h90);
        check("t1_level", 32'(fifo_level), 32'd1);
        rx_ready = 1'b1;
        idle(3);
        check("t1_valid_after_pop", 32'(rx_valid), 32'd0);

        // Back-to-back frames with no idle gap.
        ferr_snap = ferr_cnt;
        ovr_snap  = ovr_cnt;
        send_byte(8'h90, 1'b1, 1'b1);
        send_byte(8'h3C, 1'b1, 1'b1);
        send_byte(8'h7F, 1'b1, 1'b1);
        idle(30);
        check("t2_drained", 32'(exp_q.size()), 32'd0);
        check("t2_no_ferr", 32'(ferr_cnt - ferr_snap), 32'd0);
        check("t2_no_ovr", 32'(ovr_cnt - ovr_snap), 32'd0);

        // Glitch shorter than half a bit is a false start.
        midi_in = 1'b0;
        wait_cycles(BIT / 4);
        idle(100);
        check("t3_valid", 32'(rx_valid), 32'd0);
        check("t3_level", 32'(fifo_level), 32'd0);
        check("t3_no_ferr", 32'(ferr_cnt - ferr_snap), 32'd0);

        // Framing error followed by a long break, then a good byte.
        send_byte(8'h45, 1'b0, 1'b0);
        midi_in = 1'b0;
        wait_cycles(BIT * 12);
        idle(20);
        send_byte(8'h80, 1'b1, 1'b1);
        idle(30);
        check("t4_ferr_once", 32'(ferr_cnt - ferr_snap), 32'd1);
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // Overrun: fifth byte with a full FIFO and no consumer is dropped.
        rx_ready  = 1'b0;
        ovr_snap  = ovr_cnt;
        for (int i = 0; i < 5; i++) burst[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) send_byte(burst[i], 1'b1, i < DEPTH);
        idle(30);
        check("t5_level_full", 32'(fifo_level), 32'(DEPTH));
        check("t5_ovr_once", 32'(ovr_cnt - ovr_snap), 32'd1);
        check("t5_head", 32'(rx_data), 32'(burst[0]));
        rx_ready = 1'b1;
        idle(10);
        check("t5_drained", 32'(exp_q.size()), 32'd0);
        check("t5_level_empty", 32'(fifo_level), 32'd0);

        // Pop in the very cycle the fifth byte is pushed: no overrun.
        rx_ready = 1'b0;
        ovr_snap = ovr_cnt;
        for (int i = 0; i < 5; i++) burst[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) send_byte(burst[i], 1'b1, 1'b1);
        fork
            send_byte(burst[4], 1'b1, 1'b1);
            begin
                repeat (BIT * 9 + BIT / 2 + 3) @(posedge sys_clk);
                #1 rx_ready = 1'b1;
                @(posedge sys_clk);
                #1 rx_ready = 1'b0;
            end
        join
        idle(30);
        check("t5b_no_ovr", 32'(ovr_cnt - ovr_snap), 32'd0);
        check("t5b_level_full", 32'(fifo_level), 32'(DEPTH));
        rx_ready = 1'b1;
        idle(10);
        check("t5b_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a frame, with a byte already waiting.
        rx_ready = 1'b0;
        send_byte(8'h11, 1'b1, 1'b1);
        idle(20);
        fork
            send_byte(8'h55, 1'b1, 1'b1);
            begin
                wait_cycles(BIT * 4);
                sys_rst  = 1'b1;
                abort_tx = 1'b1;
            end
        join
        wait_cycles(2);
        check_reset_outputs("midreset");
        exp_q.delete();
        idle(5);
        abort_tx = 1'b0;
        sys_rst  = 1'b0;
        idle(10);
        rx_ready = 1'b1;
        send_byte(8'hAA, 1'b1, 1'b1);
        idle(30);
        check("t6_drained", 32'(exp_q.size()), 32'd0);
        check("t6_level", 32'(fifo_level), 32'd0);

        // Random bytes, random gaps, random consumer stalls.
        ferr_snap  = ferr_cnt;
        ovr_snap   = ovr_cnt;
        rand_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send_byte(8'($urandom), 1'b1, 1'b1);
            idle($urandom_range(0, 20));
        end
        idle(40);
        rand_ready = 1'b0;
        wait_cycles(1);
        rx_ready = 1'b1;
        idle(20);
        check("t7_drained", 32'(exp_q.size()), 32'd0);
        check("t7_no_ferr", 32'(ferr_cnt - ferr_snap), 32'd0);
        check("t7_no_ovr", 32'(ovr_cnt - ovr_snap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
